// File: rtl/instr_assembler.sv
// Packs decoded I/B/J instruction fields into RV32 words and streams them into imem.
// Optional immediate range checking is enabled by defining IMM_RANGE_CHECK_EN.
module instr_assembler #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned CNT_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  count,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [31:0]       in_imm,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    input  logic              wr_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  err_idx
);

    // Format codes shared with the core's immediate generator.
    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd4;

    typedef enum logic [1:0] {StIdle, StLoad, StDrain} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, acc_q;
    logic [ADDR_W-1:0]  next_addr_q, wr_addr_q;
    logic [31:0]        wr_data_q, enc_word;
    logic               wr_en_q, zero_done_q;
    logic               start_ok, accept;

    assign start_ok = start && (state_q == StIdle);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start && count != '0) state_d = StLoad;
            StLoad:  if (acc_q == cnt_q) state_d = StDrain;
            StDrain: if (!wr_en_q) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready = (state_q == StLoad) && (acc_q != cnt_q) && (!wr_en_q || wr_ready);
        busy     = (state_q != StIdle);
        // The final write has left the output register once wr_en drops in DRAIN.
        done     = ((state_q == StDrain) && !wr_en_q) || zero_done_q;
    end

    always_comb begin
        enc_word = 32'h0000_0013;
        case (in_fmt)
            IMM_I: enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            IMM_B: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                               in_imm[4:1], in_imm[11], in_opcode};
            IMM_J: enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                               in_rd, in_opcode};
            default: enc_word = 32'h0000_0013;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            next_addr_q <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_en_q     <= 1'b0;
            zero_done_q <= 1'b0;
        end else begin
            zero_done_q <= start_ok && (count == '0);
            if (start_ok) begin
                cnt_q       <= count;
                acc_q       <= '0;
                next_addr_q <= {base_addr[ADDR_W-1:2], 2'b00};
            end
            if (accept) begin
                wr_en_q     <= 1'b1;
                wr_addr_q   <= next_addr_q;
                wr_data_q   <= enc_word;
                next_addr_q <= next_addr_q + ADDR_W'(4);
                acc_q       <= acc_q + CNT_W'(1);
            end else if (wr_ready) begin
                wr_en_q <= 1'b0;
            end
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

`ifdef IMM_RANGE_CHECK_EN
    logic             imm_bad, err_q;
    logic [CNT_W-1:0] err_idx_q;

    // An immediate fits when all bits above its sign bit equal the sign bit.
    always_comb begin
        imm_bad = 1'b1;
        case (in_fmt)
            IMM_I: imm_bad = !((&in_imm[31:11]) || !(|in_imm[31:11]));
            IMM_B: imm_bad = !((&in_imm[31:12]) || !(|in_imm[31:12])) || in_imm[0];
            IMM_J: imm_bad = !((&in_imm[31:20]) || !(|in_imm[31:20])) || in_imm[0];
            default: imm_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q     <= 1'b0;
            err_idx_q <= '0;
        end else if (start_ok) begin
            err_q     <= 1'b0;
            err_idx_q <= '0;
        end else if (accept && imm_bad && !err_q) begin
            err_q     <= 1'b1;
            err_idx_q <= acc_q;
        end
    end

    assign err     = err_q;
    assign err_idx = err_idx_q;
`else
    logic unused_imm;
    assign unused_imm = ^in_imm[31:21];
    assign err        = 1'b0;
    assign err_idx    = '0;
`endif

endmodule

// File: doc/instr_assembler.md
Name: instr_assembler

Overview:
- Encoder counterpart to the core's immediate generator. Accepts decoded instruction fields and a signed immediate, and packs them into 32-bit RV32 I/B/J-type words.
- Streams the packed words into instruction memory at consecutive word addresses.
- Used by the test/boot path to load programs (e.g. the Fibonacci kernel) into imem before the core leaves reset.

Parameters:
- ADDR_W, 12, byte-address width of the imem write port.
- CNT_W, 10, width of the instruction-count field.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; latches base_addr and count
- base_addr  in  ADDR_W  first byte address; bits [1:0] ignored, treated as 0
- count  in  CNT_W  number of instructions to load
- in_valid  in  1  field bundle valid
- in_ready  out  1  field bundle accepted when in_valid && in_ready
- in_fmt  in  3  IMM_I / IMM_B / IMM_J codes from defines.svh
- in_opcode  in  7  opcode[6:0]
- in_rd  in  5  rd (I, J)
- in_rs1  in  5  rs1 (I, B)
- in_rs2  in  5  rs2 (B)
- in_funct3  in  3  funct3 (I, B)
- in_imm  in  32  signed immediate, byte offset for B/J
- wr_en  out  1  imem write request
- wr_addr  out  ADDR_W  write byte address
- wr_data  out  32  encoded word
- wr_ready  in  1  imem accepts the write when wr_en && wr_ready
- busy  out  1  load in progress
- done  out  1  one-cycle pulse at end of load
- err  out  1  sticky encode error
- err_idx  out  CNT_W  index of the first erroneous instruction

Behaviour:
- Reset values: state IDLE; in_ready, wr_en, busy, done, err = 0; wr_addr, wr_data, err_idx = 0.
- States:
  - IDLE: start → LOAD when count != 0. start with count == 0 → done pulses next cycle, state stays IDLE, no writes.
  - LOAD: busy = 1. When the accepted-instruction counter equals count, stop accepting and go to DRAIN.
  - DRAIN: busy = 1. Wait for the final write to be accepted, then go to IDLE and pulse done for one cycle.
- start outside IDLE is ignored. A new start clears err and err_idx.
- One-entry output register:
  - in_ready = (state == LOAD) && (count not yet reached) && (!wr_en || wr_ready).
  - An accepted bundle appears on wr_en/wr_data/wr_addr on the next cycle (latency 1).
  - wr_en, wr_addr and wr_data hold stable while wr_en && !wr_ready.
  - Back-to-back accepts sustain 1 word/cycle while wr_ready = 1.
- Addressing: first write goes to base_addr; each accepted write advances the address by 4, wrapping modulo 2^ADDR_W.
- Encoding:
  - Common fields: [6:0] = opcode. [11:7] = rd for I/J. [14:12] = funct3 and [19:15] = rs1 for I/B. [24:20] = rs2 for B.
  - I: [31:20] = imm[11:0].
  - B: [31] = imm[12], [30:25] = imm[10:5], [11:8] = imm[4:1], [7] = imm[11].
  - J: [31] = imm[20], [30:21] = imm[10:1], [20] = imm[11], [19:12] = imm[19:12].
  - Any other fmt: word = 32'h0000_0013 (NOP).
- Immediate bits above the field width are discarded. B/J imm[0] is discarded.
- Reset mid-operation: all state aborts immediately; any pending write is dropped (wr_en = 0).
- done and a new start in the same cycle: start is honoured only once state is IDLE (the cycle after done).

Optional Feature:
- Macro: IMM_RANGE_CHECK_EN.
- Defined: a bundle is flagged as an error if any of these hold:
  - I imm is outside [-2048, 2047].
  - B imm is outside [-4096, 4094], or imm[0] = 1.
  - J imm is outside [-1048576, 1048574], or imm[0] = 1.
  - fmt is unsupported.
- On the first flagged bundle after start: err is set (sticky) and err_idx = its 0-based index. Later errors do not change err_idx. The word is still written, truncated per the encoding rules.
- Not defined: no checking; err and err_idx stay 0.

Test Plan:
- start base = 0x000, count = 3, wr_ready = 1. Send:
  - I: opcode 0010011, rd 1, rs1 0, funct3 0, imm 5.
  - B: opcode 1100011, rs1 1, rs2 2, funct3 0, imm -8.
  - J: opcode 1101111, rd 1, imm 16.
  - Expected: writes 0x00500093 @0x000, 0xFE208CE3 @0x004, 0x010000EF @0x008 on consecutive cycles; done pulses 1 cycle after the last write; err = 0.
- Hold wr_ready = 0 for 3 cycles during the second write → in_ready = 0; wr_addr/wr_data stable at 0x004 / 0xFE208CE3; no write lost or duplicated.
- start count = 0 → done pulses next cycle; wr_en never asserts.
- base = 0xFFC, count = 2 → writes at 0xFFC then 0x000.
- With IMM_RANGE_CHECK_EN, count = 3: I imm 4096 at index 1 and B imm 3 at index 2 → err = 1, err_idx = 1; both words still written.
- Assert rst_n low mid-load after 1 of 3 writes → all outputs return to reset values; a fresh start then loads correctly from the new base.
